wb_lsu: RTL and testbench

Load/store unit sitting between the core's memory stage and the Wishbone data RAM. It converts one core load or store request into classic single Wishbone cycles, with byte-lane selection and sign/zero extension for loads. The data RAM has no byte-select lines, so sub-word stores are done as a read-modify-write. It also reports misaligned and illegal accesses, bus errors and bus timeouts.

---
 rtl/wb_lsu.sv | 92 +++++++++
 tb/tb_wb_lsu.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/wb_lsu.sv
// wb_lsu: load/store unit turning core requests into classic Wishbone cycles, with RMW for sub-word stores
module wb_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        CYC,
    output logic        STB,
    output logic        WE,
    output logic [31:0] ADR,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic [2:0]  CTI_O,
    input  logic        ACK,
    input  logic        ERR,
    input  logic        RTY
);
    typedef enum logic [2:0] {IDLE, RD, MOD, WR, DONE} state_t;
    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);
    state_t      st;
    logic [1:0]  a;
    logic [2:0]  f3;
    logic        w, fail, retry, bad;
    logic [31:0] wd, wrd, ext, mrg;
    logic [15:0] cnt, h;
    logic [7:0]  b;
    assign STB = CYC;
    assign CTI_O = 3'b000;
    assign bad = (we ? (funct3 > 3'd2) : (funct3 == 3'd3 || funct3[2:1] == 2'b11))
               || (funct3[1:0] == 2'b01 && addr[0])
               || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign h = a[1] ? DAT_I[31:16] : DAT_I[15:0];
    assign b = a[0] ? h[15:8] : h[7:0];
    assign ext = f3[1:0] == 2'b00 ? {{24{b[7] & ~f3[2]}}, b}
               : f3[1:0] == 2'b01 ? {{16{h[15] & ~f3[2]}}, h} : DAT_I;
    // merge store data into the captured word on its little-endian lane; SW passes wdata through
    always_comb begin
        mrg = wrd;
        if (f3[1]) mrg = wd;
        else if (f3[0]) mrg = a[1] ? {wd[15:0], wrd[15:0]} : {wrd[31:16], wd[15:0]};
        else mrg[{a, 3'b000} +: 8] = wd[7:0];
    end
    // request sequencing, bus handshake, timeout and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE; CYC <= 1'b0; WE <= 1'b0; ADR <= '0; DAT_O <= '0; rdata <= '0;
            done <= 1'b0; err <= 1'b0; busy <= 1'b0; cnt <= '0; a <= '0; f3 <= '0;
            w <= 1'b0; wd <= '0; wrd <= '0; fail <= 1'b0; retry <= 1'b0;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            case (st)
                IDLE: if (req) begin
                    a <= addr[1:0]; f3 <= funct3; w <= we; wd <= wdata;
                    ADR <= {addr[31:2], 2'b00}; DAT_O <= wdata;
                    cnt <= '0; retry <= 1'b0; fail <= bad; busy <= 1'b1;
                    st <= bad ? DONE : (we && funct3 == 3'd2) ? WR : RD;
                    CYC <= !bad;
                    WE <= !bad && we && funct3 == 3'd2;
                end
                RD, WR: if (ACK || ERR || RTY || cnt == TLAST) begin
                    CYC <= 1'b0; WE <= 1'b0;
                    st <= ACK ? ((st == RD && w) ? MOD : DONE) : (ERR || !RTY) ? DONE : MOD;
                    fail <= !ACK && (ERR || !RTY);
                    retry <= !ACK && !ERR && RTY && st == RD;
                    if (ACK && st == RD) begin
                        wrd <= DAT_I;
                        if (!w) rdata <= ext;
                    end
                end else cnt <= cnt + 16'd1;
                MOD: begin
                    CYC <= 1'b1; cnt <= '0; WE <= !retry;
                    st <= retry ? RD : WR;
                    if (!retry) DAT_O <= mrg;
                end
                DONE: begin
                    done <= 1'b1; err <= fail; busy <= 1'b0; st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_lsu.sv
// tb_wb_lsu: directed vector bench for wb_lsu against a registered Wishbone RAM stub
module tb_wb_lsu;
    logic clk = 0, rst = 0, req = 0, we = 0;
    logic [2:0] funct3 = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [31:0] rdata, ADR, DAT_O, dat_i;
    logic done, err, busy, CYC, STB, WE;
    logic [2:0] CTI_O;
    logic ack = 0, serr = 0, srty = 0;
    logic [31:0] mem [16];
    int mode = 0, tag = 0, dtag = 0;
    logic pre_go = 0;
    logic [3:0] pre_idx = 0;
    logic [31:0] pre_val = 0;
    int tests = 0, fails = 0;

    typedef struct {
        logic w; logic [2:0] f; logic [31:0] ad, wd;
        logic pre_en; logic [31:0] pre; int mode;
        int lat, hi, rises; logic e; logic [31:0] rd, dat;
    } vec_t;
    vec_t v [20];

    wb_lsu #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .err(err), .busy(busy), .CYC(CYC), .STB(STB), .WE(WE),
        .ADR(ADR), .DAT_O(DAT_O), .DAT_I(dat_i), .CTI_O(CTI_O), .ACK(ack), .ERR(serr), .RTY(srty)
    );

    always #5 clk = ~clk;
    assign dat_i = mem[ADR[5:2]];

    // slave stub: responds one edge after sampling STB; modes 1 silent, 2 ERR once, 3 RTY once
    always @(posedge clk) begin
        ack <= 0; serr <= 0; srty <= 0;
        if (pre_go) mem[pre_idx] <= pre_val;
        if (CYC && STB && mode != 1) begin
            if (mode >= 2 && dtag != tag) begin
                dtag <= tag;
                if (mode == 2) serr <= 1; else srty <= 1;
            end else begin
                ack <= 1;
                if (WE) mem[ADR[5:2]] <= DAT_O;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t t, output int lat, output int hi, output int rises, output logic [31:0] dat);
        logic prev;
        if (t.pre_en) begin
            @(negedge clk); pre_go = 1; pre_idx = t.ad[5:2]; pre_val = t.pre;
            @(negedge clk); pre_go = 0;
        end
        mode = t.mode; tag++;
        @(negedge clk); req = 1; we = t.w; funct3 = t.f; addr = t.ad; wdata = t.wd;
        @(posedge clk); #1 req = 0;
        lat = 0; hi = 0; rises = 0; dat = 0; prev = 0;
        while (!done && lat < 40) begin
            if (STB) begin hi++; if (WE) dat = DAT_O; end
            if (STB && !prev) rises++;
            prev = STB;
            @(posedge clk); #1 lat++;
        end
    endtask

    initial begin
        int lat, hi, rises, first, second, nd;
        logic [31:0] dat;
        logic pb;
        //          w  f     ad     wd            pre pre_val       md lat hi rs e  rd             dat
        v[0]  = '{0, 3'd2, 32'h10, 32'h0,        1, 32'h8899AABB, 0, 3, 2, 1, 0, 32'h8899AABB, 32'h0};
        v[1]  = '{0, 3'd0, 32'h13, 32'h0,        0, 32'h0,        0, 3, 2, 1, 0, 32'hFFFFFF88, 32'h0};
        v[2]  = '{0, 3'd4, 32'h13, 32'h0,        0, 32'h0,        0, 3, 2, 1, 0, 32'h00000088, 32'h0};
        v[3]  = '{0, 3'd1, 32'h12, 32'h0,        0, 32'h0,        0, 3, 2, 1, 0, 32'hFFFF8899, 32'h0};
        v[4]  = '{0, 3'd5, 32'h10, 32'h0,        0, 32'h0,        0, 3, 2, 1, 0, 32'h0000AABB, 32'h0};
        v[5]  = '{0, 3'd0, 32'h10, 32'h0,        0, 32'h0,        0, 3, 2, 1, 0, 32'hFFFFFFBB, 32'h0};
        v[6]  = '{1, 3'd0, 32'h11, 32'h55,       1, 32'h11223344, 0, 6, 4, 2, 0, 32'hFFFFFFBB, 32'h11225544};
        v[7]  = '{0, 3'd2, 32'h10, 32'h0,        0, 32'h0,        0, 3, 2, 1, 0, 32'h11225544, 32'h0};
        v[8]  = '{1, 3'd1, 32'h16, 32'hCAFEBEEF, 1, 32'h01020304, 0, 6, 4, 2, 0, 32'h11225544, 32'hBEEF0304};
        v[9]  = '{1, 3'd2, 32'h20, 32'hDEADBEEF, 0, 32'h0,        0, 3, 2, 1, 0, 32'h11225544, 32'hDEADBEEF};
        v[10] = '{0, 3'd2, 32'h20, 32'h0,        0, 32'h0,        0, 3, 2, 1, 0, 32'hDEADBEEF, 32'h0};
        v[11] = '{0, 3'd1, 32'h03, 32'h0,        0, 32'h0,        0, 1, 0, 0, 1, 32'hDEADBEEF, 32'h0};
        v[12] = '{0, 3'd3, 32'h10, 32'h0,        0, 32'h0,        0, 1, 0, 0, 1, 32'hDEADBEEF, 32'h0};
        v[13] = '{1, 3'd2, 32'h22, 32'h1,        0, 32'h0,        0, 1, 0, 0, 1, 32'hDEADBEEF, 32'h0};
        v[14] = '{1, 3'd4, 32'h10, 32'h1,        0, 32'h0,        0, 1, 0, 0, 1, 32'hDEADBEEF, 32'h0};
        v[15] = '{0, 3'd2, 32'h10, 32'h0,        0, 32'h0,        1, 9, 8, 1, 1, 32'hDEADBEEF, 32'h0};
        v[16] = '{0, 3'd2, 32'h10, 32'h0,        0, 32'h0,        2, 3, 2, 1, 1, 32'hDEADBEEF, 32'h0};
        v[17] = '{0, 3'd2, 32'h10, 32'h0,        0, 32'h0,        3, 6, 4, 2, 0, 32'h11225544, 32'h0};
        v[18] = '{1, 3'd2, 32'h24, 32'h12345678, 0, 32'h0,        3, 6, 4, 2, 0, 32'h11225544, 32'h12345678};
        v[19] = '{0, 3'd2, 32'h24, 32'h0,        0, 32'h0,        0, 3, 2, 1, 0, 32'h12345678, 32'h0};

        #1 rst = 1;
        #1;
        chk("reset ctrl", {26'd0, CYC, STB, WE, done, err, busy}, 32'h0);
        chk("reset ADR", ADR, 32'h0);
        chk("reset DAT_O", DAT_O, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset CTI_O", {29'd0, CTI_O}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;

        for (int i = 0; i < 20; i++) begin
            run(v[i], lat, hi, rises, dat);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(v[i].lat));
            chk($sformatf("v%0d stb_cycles", i), 32'(hi), 32'(v[i].hi));
            chk($sformatf("v%0d stb_pulses", i), 32'(rises), 32'(v[i].rises));
            chk($sformatf("v%0d err", i), {31'd0, err}, {31'd0, v[i].e});
            chk($sformatf("v%0d rdata", i), rdata, v[i].rd);
            chk($sformatf("v%0d cyc_busy_at_done", i), {30'd0, CYC, busy}, 32'h0);
            if (v[i].w && !v[i].e) chk($sformatf("v%0d dat_o", i), dat, v[i].dat);
        end

        mode = 0; tag++;
        @(negedge clk); req = 1; we = 0; funct3 = 3'd2; addr = 32'h10;
        first = -1; second = -1; pb = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (busy && !pb) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            pb = busy;
        end
        req = 0;
        chk("b2b spacing", 32'(second - first), 32'd4);
        for (int k = 0; k < 40 && busy; k++) begin @(posedge clk); #1; end
        @(posedge clk); #1;

        tag++;
        @(negedge clk); req = 1; we = 1; funct3 = 3'd2; addr = 32'h28; wdata = 32'hA5A5A5A5;
        @(posedge clk); #1 req = 0;
        chk("rst pre stb_we", {30'd0, STB, WE}, 32'h3);
        #2 rst = 1;
        #1;
        chk("rst async bus", {28'd0, CYC, STB, WE, busy}, 32'h0);
        @(negedge clk) rst = 0;
        nd = 0;
        for (int k = 0; k < 6; k++) begin @(posedge clk); #1 if (done) nd++; end
        chk("rst no done", 32'(nd), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
